// File: rtl/encoder_tuning_word_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_tuning_word_pkg
//  Description : Shared definitions for the rotary-encoder tuning-word block:
//                decode FSM state encoding and the default debounce length
//                for a 25 MHz system clock.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package encoder_tuning_word_pkg;

    // 4 us of stability at 25 MHz before a contact level is accepted.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 100;

    // Decode FSM states. The comment after each state is the debounced
    // {A,B} level the state corresponds to.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,  // 11
        ST_CW1  = 3'd1,  // 01
        ST_CW2  = 3'd2,  // 00
        ST_CW3  = 3'd3,  // 10
        ST_CCW1 = 3'd4,  // 10
        ST_CCW2 = 3'd5,  // 00
        ST_CCW3 = 3'd6,  // 01
        ST_WAIT = 3'd7   // invalid sequence, wait for 11
    } state_t;

endpackage : encoder_tuning_word_pkg
`default_nettype wire

// File: rtl/encoder_tuning_word_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : 2-FF synchronizer followed by a stability counter for one
//                raw mechanical contact. The output follows the input only
//                after the synchronized value has differed from the current
//                output for CYCLES consecutive clocks.
//  Ports       : Clock    - system clock, rising edge
//                Reset    - asynchronous active-high reset
//                Input_i  - raw asynchronous contact, idles high
//                Output_o - debounced level (resets to 1)
//  Revision    : 1.0  initial release
// ============================================================================
module input_debouncer
    import encoder_tuning_word_pkg::*;
#(
    parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Input_i,
    output logic Output_o
);

    localparam int               CNT_W    = $clog2(CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            count_q <= '0;
        end else begin
            sync1_q <= Input_i;
            sync2_q <= sync1_q;
            // The counter only runs while the synchronized input disagrees
            // with the accepted level; a glitch that returns early lands in
            // the first branch and throws away the partial count.
            if (sync2_q == level_q) begin
                count_q <= '0;
            end else if (count_q == CNT_LAST) begin
                level_q <= sync2_q;
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign Output_o = level_q;

endmodule : input_debouncer
`default_nettype wire

// File: rtl/encoder_tuning_word.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_tuning_word
//  Description : Converts a bouncing rotary quadrature encoder into a
//                clamped, registered DDS tuning word. One full valid detent
//                (11 -> 01 -> 00 -> 10 -> 11 clockwise, mirrored for
//                counter-clockwise) produces one step of STEP.
//  Ports       : Clock        - system clock, rising edge
//                Reset        - asynchronous active-high reset
//                EncoderA_i   - raw encoder channel A, idles high
//                EncoderB_i   - raw encoder channel B, idles high
//                TuningWord_o - current tuning word (registered)
//                Up_o         - 1-cycle pulse per accepted CW detent
//                Down_o       - 1-cycle pulse per accepted CCW detent
//                Changed_o    - 1-cycle pulse when TuningWord_o changed
//  Revision    : 1.0  initial release
// ============================================================================
module encoder_tuning_word
    import encoder_tuning_word_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter logic [WIDTH-1:0] STEP            = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [WIDTH-1:0] MIN_WORD        = '0,
    parameter logic [WIDTH-1:0] MAX_WORD        = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT_WORD       = '0,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             EncoderA_i,
    input  logic             EncoderB_i,
    output logic [WIDTH-1:0] TuningWord_o,
    output logic             Up_o,
    output logic             Down_o,
    output logic             Changed_o
);

    generate
        if (STEP == '0 || MIN_WORD > INIT_WORD || INIT_WORD > MAX_WORD) begin : g_param_check
            $error("encoder_tuning_word: need STEP >= 1 and MIN_WORD <= INIT_WORD <= MAX_WORD");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic a_deb;
    logic b_deb;

    input_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .Clock    (Clock),
        .Reset    (Reset),
        .Input_i  (EncoderA_i),
        .Output_o (a_deb)
    );

    input_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .Clock    (Clock),
        .Reset    (Reset),
        .Input_i  (EncoderB_i),
        .Output_o (b_deb)
    );

    logic [1:0] ab;
    logic [1:0] ab_prev_q;
    logic       one_chg;
    logic       both_chg;

    assign ab       = {a_deb, b_deb};
    assign one_chg  = (ab[1] != ab_prev_q[1]) ^ (ab[0] != ab_prev_q[0]);
    assign both_chg = (ab[1] != ab_prev_q[1]) & (ab[0] != ab_prev_q[0]);

    // ------------------------------------------------------------------
    // Clamped next-word candidates. The extra top bit keeps word+STEP and
    // MIN_WORD+STEP from wrapping, so the compares stay honest at the
    // ends of the range.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   word_ext;
    logic [WIDTH-1:0] word_up_d;
    logic [WIDTH-1:0] word_dn_d;

    always_comb begin
        word_up_d = TuningWord_o;
        word_dn_d = TuningWord_o;
        word_ext  = {1'b0, TuningWord_o};
        if (word_ext + {1'b0, STEP} > {1'b0, MAX_WORD}) begin
            word_up_d = MAX_WORD;
        end else begin
            word_up_d = TuningWord_o + STEP;
        end
        if (word_ext < {1'b0, MIN_WORD} + {1'b0, STEP}) begin
            word_dn_d = MIN_WORD;
        end else begin
            word_dn_d = TuningWord_o - STEP;
        end
    end

    // ------------------------------------------------------------------
    // Decode FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic             up_q;
    logic             down_q;
    logic             changed_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            ab_prev_q <= 2'b11;
            word_q    <= INIT_WORD;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            ab_prev_q <= ab;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            changed_q <= 1'b0;

            if (state_q == ST_WAIT) begin
                if (ab == 2'b11) begin
                    state_q <= ST_IDLE;
                end
            end else if (both_chg) begin
                state_q <= ST_WAIT;
            end else if (one_chg) begin
                // A single-bit change means the new {A,B} alone identifies
                // whether this is a forward or a backward Gray step.
                case (state_q)
                    ST_IDLE: begin
                        if (ab == 2'b01)      state_q <= ST_CW1;
                        else if (ab == 2'b10) state_q <= ST_CCW1;
                    end
                    ST_CW1: begin
                        if (ab == 2'b00)      state_q <= ST_CW2;
                        else if (ab == 2'b11) state_q <= ST_IDLE;
                    end
                    ST_CW2: begin
                        if (ab == 2'b10)      state_q <= ST_CW3;
                        else if (ab == 2'b01) state_q <= ST_CW1;
                    end
                    ST_CW3: begin
                        if (ab == 2'b11) begin
                            state_q   <= ST_IDLE;
                            up_q      <= 1'b1;
                            word_q    <= word_up_d;
                            changed_q <= (word_up_d != word_q);
                        end else if (ab == 2'b00) begin
                            state_q <= ST_CW2;
                        end
                    end
                    ST_CCW1: begin
                        if (ab == 2'b00)      state_q <= ST_CCW2;
                        else if (ab == 2'b11) state_q <= ST_IDLE;
                    end
                    ST_CCW2: begin
                        if (ab == 2'b01)      state_q <= ST_CCW3;
                        else if (ab == 2'b10) state_q <= ST_CCW1;
                    end
                    ST_CCW3: begin
                        if (ab == 2'b11) begin
                            state_q   <= ST_IDLE;
                            down_q    <= 1'b1;
                            word_q    <= word_dn_d;
                            changed_q <= (word_dn_d != word_q);
                        end else if (ab == 2'b00) begin
                            state_q <= ST_CCW2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TuningWord_o = word_q;
    assign Up_o         = up_q;
    assign Down_o       = down_q;
    assign Changed_o    = changed_q;

endmodule : encoder_tuning_word
`default_nettype wire

// File: tb/tb_encoder_tuning_word.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_tuning_word
//  Description : Directed self-checking bench for encoder_tuning_word.
//                Three instances share clock, reset and encoder inputs:
//                a default 32-bit one, one clamping at MAX_WORD=12 and one
//                clamping at MIN_WORD=3 (both STEP=5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder_tuning_word;

    localparam int GAP = 250;  // 10 us at 25 MHz

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enc_a = 1'b1;
    logic enc_b = 1'b1;

    always #20 clk = ~clk;  // 25 MHz

    logic [31:0] word_m;
    logic        up_m, dn_m, ch_m;
    logic [7:0]  word_x;
    logic        up_x, dn_x, ch_x;
    logic [7:0]  word_n;
    logic        up_n, dn_n, ch_n;

    encoder_tuning_word #(
        .WIDTH(32), .STEP(32'd1), .MIN_WORD(32'd0), .MAX_WORD(32'hFFFF_FFFF),
        .INIT_WORD(32'd0), .DEBOUNCE_CYCLES(100)
    ) u_main (
        .Clock(clk), .Reset(rst), .EncoderA_i(enc_a), .EncoderB_i(enc_b),
        .TuningWord_o(word_m), .Up_o(up_m), .Down_o(dn_m), .Changed_o(ch_m)
    );

    encoder_tuning_word #(
        .WIDTH(8), .STEP(8'd5), .MIN_WORD(8'd0), .MAX_WORD(8'd12),
        .INIT_WORD(8'd10), .DEBOUNCE_CYCLES(100)
    ) u_max (
        .Clock(clk), .Reset(rst), .EncoderA_i(enc_a), .EncoderB_i(enc_b),
        .TuningWord_o(word_x), .Up_o(up_x), .Down_o(dn_x), .Changed_o(ch_x)
    );

    encoder_tuning_word #(
        .WIDTH(8), .STEP(8'd5), .MIN_WORD(8'd3), .MAX_WORD(8'd200),
        .INIT_WORD(8'd5), .DEBOUNCE_CYCLES(100)
    ) u_min (
        .Clock(clk), .Reset(rst), .EncoderA_i(enc_a), .EncoderB_i(enc_b),
        .TuningWord_o(word_n), .Up_o(up_n), .Down_o(dn_n), .Changed_o(ch_n)
    );

    int checks = 0;
    int errors = 0;

    // Pulse counters, sampled mid-cycle.
    int n_up_m = 0, n_dn_m = 0, n_ch_m = 0;
    int n_up_x = 0, n_ch_x = 0;
    int n_dn_n = 0, n_ch_n = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (up_m) n_up_m++;
        if (dn_m) n_dn_m++;
        if (ch_m) n_ch_m++;
        if (up_x) n_up_x++;
        if (ch_x) n_ch_x++;
        if (dn_n) n_dn_n++;
        if (ch_n) n_ch_n++;
        if ((up_m && dn_m) || (up_x && dn_x) || (up_n && dn_n)) n_both++;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic a, input logic b);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
    endtask

    task automatic cw_detent();
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b0, 1'b0); hold(GAP);
        set_ab(1'b1, 1'b0); hold(GAP);
        set_ab(1'b1, 1'b1); hold(2 * GAP);
    endtask

    task automatic ccw_detent();
        set_ab(1'b1, 1'b0); hold(GAP);
        set_ab(1'b0, 1'b0); hold(GAP);
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b1, 1'b1); hold(2 * GAP);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(5);
    endtask

    task automatic test_reset();
        hold(1);
        checks++;
        if (word_m !== 32'd0 || up_m !== 1'b0 || dn_m !== 1'b0 || ch_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_main: word=%0d up=%b dn=%b ch=%b, required 0/0/0/0", word_m, up_m, dn_m, ch_m);
        end
        checks++;
        if (word_x !== 8'd10 || word_n !== 8'd5) begin
            errors++;
            $display("FAIL reset_init: max-dut=%0d min-dut=%0d, required 10 and 5", word_x, word_n);
        end
        rst = 1'b0;
        hold(5);
    endtask

    task automatic test_count_up();
        int up0, ch0, dn0, cyc;
        up0 = n_up_m; ch0 = n_ch_m; dn0 = n_dn_m;
        for (int i = 0; i < 9; i++) begin
            cw_detent();
            checks++;
            if (word_m !== 32'(i + 1)) begin
                errors++;
                $display("FAIL up_step%0d: word=%0d, required %0d", i, word_m, i + 1);
            end
        end
        // Last detent: measure raw-edge-to-event latency.
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b0, 1'b0); hold(GAP);
        set_ab(1'b1, 1'b0); hold(GAP);
        set_ab(1'b1, 1'b1);
        cyc = 0;
        while (!up_m && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 103) begin
            errors++;
            $display("FAIL up_latency: %0d cycles, required 103", cyc);
        end
        hold(2 * GAP);
        checks++;
        if (word_m !== 32'd10 || n_up_m - up0 != 10 || n_ch_m - ch0 != 10 || n_dn_m != dn0) begin
            errors++;
            $display("FAIL count_up: word=%0d ups=%0d changed=%0d downs=%0d, required 10/10/10/0",
                     word_m, n_up_m - up0, n_ch_m - ch0, n_dn_m - dn0);
        end
    endtask

    task automatic test_count_down();
        int up0, ch0, dn0;
        up0 = n_up_m; ch0 = n_ch_m; dn0 = n_dn_m;
        for (int i = 0; i < 3; i++) begin
            ccw_detent();
            checks++;
            if (word_m !== 32'(9 - i)) begin
                errors++;
                $display("FAIL down_step%0d: word=%0d, required %0d", i, word_m, 9 - i);
            end
        end
        checks++;
        if (n_dn_m - dn0 != 3 || n_ch_m - ch0 != 3 || n_up_m != up0) begin
            errors++;
            $display("FAIL count_down: downs=%0d changed=%0d ups=%0d, required 3/3/0",
                     n_dn_m - dn0, n_ch_m - ch0, n_up_m - up0);
        end
    endtask

    task automatic test_glitch();
        int up0, ch0, dn0;
        up0 = n_up_m; ch0 = n_ch_m; dn0 = n_dn_m;
        repeat (2) begin
            set_ab(1'b0, 1'b1); hold(50);   // 2 us low pulse on A
            set_ab(1'b1, 1'b1); hold(GAP);
        end
        repeat (3) begin
            repeat (10) begin
                set_ab(1'b1, 1'b0);
                set_ab(1'b1, 1'b1);
            end
            hold(GAP);
        end
        checks++;
        if (word_m !== 32'd7 || n_up_m != up0 || n_dn_m != dn0 || n_ch_m != ch0) begin
            errors++;
            $display("FAIL glitch: word=%0d ups=%0d downs=%0d changed=%0d, required 7/0/0/0",
                     word_m, n_up_m - up0, n_dn_m - dn0, n_ch_m - ch0);
        end
        cw_detent();
        checks++;
        if (word_m !== 32'd8) begin
            errors++;
            $display("FAIL glitch_idle: word=%0d after detent, required 8", word_m);
        end
    endtask

    task automatic test_partial_and_wait();
        int up0, ch0, dn0;
        up0 = n_up_m; ch0 = n_ch_m; dn0 = n_dn_m;
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b0, 1'b0); hold(GAP);
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b1, 1'b1); hold(2 * GAP);
        checks++;
        if (word_m !== 32'd8 || n_up_m != up0 || n_dn_m != dn0 || n_ch_m != ch0) begin
            errors++;
            $display("FAIL reversed: word=%0d ups=%0d downs=%0d, required 8/0/0",
                     word_m, n_up_m - up0, n_dn_m - dn0);
        end
        // Both fall together, then a tail that would finish a CCW detent.
        set_ab(1'b0, 1'b0); hold(GAP);
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b1, 1'b1); hold(2 * GAP);
        checks++;
        if (word_m !== 32'd8 || n_dn_m != dn0 || n_up_m != up0) begin
            errors++;
            $display("FAIL wait_state: word=%0d downs=%0d ups=%0d, required 8/0/0",
                     word_m, n_dn_m - dn0, n_up_m - up0);
        end
        cw_detent();
        checks++;
        if (word_m !== 32'd9 || n_up_m - up0 != 1) begin
            errors++;
            $display("FAIL after_wait: word=%0d ups=%0d, required 9/1", word_m, n_up_m - up0);
        end
    endtask

    task automatic test_clamps();
        int up0, ch0, dn0, chn0;
        pulse_reset();
        up0 = n_up_x; ch0 = n_ch_x;
        cw_detent();
        checks++;
        if (word_x !== 8'd12) begin
            errors++;
            $display("FAIL clamp_max1: word=%0d, required 12", word_x);
        end
        cw_detent();
        checks++;
        if (word_x !== 8'd12 || n_up_x - up0 != 2 || n_ch_x - ch0 != 1) begin
            errors++;
            $display("FAIL clamp_max2: word=%0d ups=%0d changed=%0d, required 12/2/1",
                     word_x, n_up_x - up0, n_ch_x - ch0);
        end
        pulse_reset();
        dn0 = n_dn_n; chn0 = n_ch_n;
        ccw_detent();
        checks++;
        if (word_n !== 8'd3) begin
            errors++;
            $display("FAIL clamp_min1: word=%0d, required 3", word_n);
        end
        ccw_detent();
        checks++;
        if (word_n !== 8'd3 || n_dn_n - dn0 != 2 || n_ch_n - chn0 != 1) begin
            errors++;
            $display("FAIL clamp_min2: word=%0d downs=%0d changed=%0d, required 3/2/1",
                     word_n, n_dn_n - dn0, n_ch_n - chn0);
        end
    endtask

    task automatic test_reset_mid_detent();
        int up0, ch0;
        pulse_reset();
        repeat (4) cw_detent();
        checks++;
        if (word_m !== 32'd4) begin
            errors++;
            $display("FAIL pre_reset: word=%0d, required 4", word_m);
        end
        set_ab(1'b0, 1'b1); hold(GAP);
        set_ab(1'b0, 1'b0); hold(GAP);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (word_m !== 32'd0 || up_m !== 1'b0 || dn_m !== 1'b0 || ch_m !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: word=%0d up=%b dn=%b ch=%b, required 0/0/0/0",
                     word_m, up_m, dn_m, ch_m);
        end
        hold(3);
        rst = 1'b0;
        up0 = n_up_m; ch0 = n_ch_m;
        hold(GAP);
        set_ab(1'b1, 1'b0); hold(GAP);
        set_ab(1'b1, 1'b1); hold(2 * GAP);
        checks++;
        if (word_m !== 32'd0 || n_up_m != up0 || n_ch_m != ch0) begin
            errors++;
            $display("FAIL discard_partial: word=%0d ups=%0d changed=%0d, required 0/0/0",
                     word_m, n_up_m - up0, n_ch_m - ch0);
        end
        cw_detent();
        checks++;
        if (word_m !== 32'd1) begin
            errors++;
            $display("FAIL fresh_start: word=%0d, required 1", word_m);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_glitch();
        test_partial_and_wait();
        test_clamps();
        test_reset_mid_detent();
        checks++;
        if (n_both != 0) begin
            errors++;
            $display("FAIL up_down_exclusive: %0d cycles with both high, required 0", n_both);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_encoder_tuning_word
`default_nettype wire
